// File: rtl/cnn_pkg.sv
// Shared CNN-pipeline definitions.
//   stream_state_t     : streamer FSM states (IDLE / STREAM)
//   DEFAULT_DATA_WIDTH : default pixel width for the conv pipeline
//   cnt_width()        : counter width for a 0..n-1 range, never below 1 bit
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } stream_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/col counter with frame-position decode.
//   clk, rst  : clock, async active-low reset
//   clr       : force row=col=0 (takes priority over adv)
//   adv       : step one pixel in raster order, wrapping at the frame end
//   row, col  : current position
//   sof       : row 0, col 0
//   eol       : last column of the current row
//   last      : last pixel of the frame
module raster_counter
    import cnn_pkg::*;
#(
    parameter int ROWS = 30,
    parameter int COLS = 30,
    parameter int RW   = cnt_width(ROWS),
    parameter int CW   = cnt_width(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          sof,
    output logic          eol,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            // Explicit compare-and-wrap so non-power-of-two sizes never
            // walk past the frame.
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign sof  = (row == '0) && (col == '0);
    assign eol  = (col == COL_MAX);
    assign last = eol && (row == ROW_MAX);

endmodule

// File: rtl/fmap_streamer.sv
// Captures a parallel feature map from the conv layer and streams it out
// one pixel per accepted beat in raster order (valid/ready handshake).
//   clk, rst    : clock, async active-low reset
//   fmap_in     : parallel feature map, sampled only on an accepted capture
//   layer_done  : fmap_in complete and valid this cycle
//   m_data      : streamed pixel (from the internal buffer)
//   m_valid     : m_data valid
//   m_ready     : downstream accepts the beat
//   m_sof       : first pixel of the frame
//   m_eol       : last pixel of a row
//   m_last      : last pixel of the frame
//   busy        : frame held / streaming
//   overrun     : sticky, a layer_done was dropped while busy
module fmap_streamer
    import cnn_pkg::*;
#(
    parameter int OUT_ROWS   = 30,
    parameter int OUT_COLS   = 30,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fmap_in [0:OUT_ROWS-1][0:OUT_COLS-1],
    input  logic                  layer_done,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int RW = cnt_width(OUT_ROWS);
    localparam int CW = cnt_width(OUT_COLS);

    stream_state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] frame [0:OUT_ROWS-1][0:OUT_COLS-1];

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          pos_sof, pos_eol, pos_last;

    logic capture, cnt_clr, cnt_adv, ovr_set;
    logic streaming, xfer;

    assign streaming = (state == S_STREAM);
    assign xfer      = streaming && m_ready;

    raster_counter #(
        .ROWS (OUT_ROWS),
        .COLS (OUT_COLS),
        .RW   (RW),
        .CW   (CW)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .adv  (cnt_adv),
        .row  (row),
        .col  (col),
        .sof  (pos_sof),
        .eol  (pos_eol),
        .last (pos_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (layer_done) begin
                    capture   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (xfer && pos_last) begin
                    // Final beat: a coincident layer_done starts the next
                    // frame back-to-back, otherwise drop to idle.
                    cnt_clr = 1'b1;
                    if (layer_done) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_adv = xfer;
                    ovr_set = layer_done;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < OUT_ROWS; r++)
                for (int c = 0; c < OUT_COLS; c++)
                    frame[r][c] <= '0;
        end else if (capture) begin
            frame <= fmap_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
    end

    // Position only moves on a transfer, so data and markers hold during
    // stalls. Gate with state so idle outputs read as zero.
    assign m_valid = streaming;
    assign busy    = streaming;
    assign m_data  = streaming ? frame[row][col] : '0;
    assign m_sof   = streaming && pos_sof;
    assign m_eol   = streaming && pos_eol;
    assign m_last  = streaming && pos_last;

endmodule
